intra4x4_sad_select: RTL and testbench

Downstream consumer of the 4x4 luma intra predictors (DC, vertical, horizontal, the diagonal modes and the rest). It accepts one 16-sample predicted block per mode over a valid/ready handshake and computes the SAD against the latched original block in a two-stage pipeline. It tracks the lowest-cost mode and reports the winning mode and its cost with a one-cycle `done` pulse, which feeds the residual/transform stage.

---
 rtl/intra4x4_sad_select.sv | 150 +++++++++++++++
 tb/tb_intra4x4_sad_select.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra4x4_sad_select.sv
// 4x4 intra mode decision: pipelined SAD per predicted block, keeps lowest cost.
// Optional INTRA4X4_MPM_BIAS_EN adds a most-probable-mode bias to every other mode.
module intra4x4_sad_select #(
    parameter int NUM_MODES = 9,
    parameter int SAD_W = 13
`ifdef INTRA4X4_MPM_BIAS_EN
    ,
    parameter int MPM_BIAS = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef INTRA4X4_MPM_BIAS_EN
    input  logic [3:0]       mpm,
`endif
    input  logic [127:0]     orig,
    input  logic             pred_valid,
    output logic             pred_ready,
    input  logic [127:0]     pred,
    input  logic [3:0]       pred_mode,
    input  logic             pred_last,
    output logic             busy,
    output logic             done,
    output logic [3:0]       best_mode,
    output logic [SAD_W-1:0] best_sad
);

    localparam int CW = $clog2(NUM_MODES + 1);
    localparam logic [CW-1:0] MAXC = CW'(NUM_MODES);
    localparam logic [CW-1:0] LASTC = CW'(NUM_MODES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] count_q;
    logic [127:0] orig_q;
    logic xfer;

    logic [127:0] abs_d;
    logic [127:0] s1_ad;
    logic [3:0] s1_mode;
    logic s1_valid;

    logic [SAD_W-1:0] sad_sum;
    logic [SAD_W-1:0] cost;
    logic [SAD_W-1:0] s2_cost;
    logic [3:0] s2_mode;
    logic s2_valid;

`ifdef INTRA4X4_MPM_BIAS_EN
    logic [3:0] mpm_q;
    logic [SAD_W:0] biased;
`endif

    assign pred_ready = (state_q == ACCUM) && (count_q < MAXC);
    assign xfer = pred_valid && pred_ready;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = ACCUM;
            ACCUM: if (xfer && (pred_last || count_q == LASTC)) state_d = DRAIN;
            DRAIN: if (!s1_valid && !s2_valid) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        abs_d = '0;
        for (int i = 0; i < 16; i++) begin
            if (pred[8*i +: 8] > orig_q[8*i +: 8])
                abs_d[8*i +: 8] = pred[8*i +: 8] - orig_q[8*i +: 8];
            else
                abs_d[8*i +: 8] = orig_q[8*i +: 8] - pred[8*i +: 8];
        end
    end

    always_comb begin
        sad_sum = '0;
        for (int i = 0; i < 16; i++)
            sad_sum = sad_sum + SAD_W'(s1_ad[8*i +: 8]);
`ifdef INTRA4X4_MPM_BIAS_EN
        biased = {1'b0, sad_sum}
               + ((s1_mode != mpm_q) ? (SAD_W+1)'(MPM_BIAS) : '0);
        // Saturate so a biased worst case never wraps below a real cost.
        cost = biased[SAD_W] ? '1 : biased[SAD_W-1:0];
`else
        cost = sad_sum;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            orig_q <= '0;
            best_mode <= '0;
            best_sad <= '0;
`ifdef INTRA4X4_MPM_BIAS_EN
            mpm_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                orig_q <= orig;
                count_q <= '0;
                best_mode <= '0;
                best_sad <= '1;
`ifdef INTRA4X4_MPM_BIAS_EN
                mpm_q <= mpm;
`endif
            end else begin
                if (xfer)
                    count_q <= count_q + 1'b1;
                // Strict compare: on a tie the earlier mode is kept.
                if (s2_valid && s2_cost < best_sad) begin
                    best_sad <= s2_cost;
                    best_mode <= s2_mode;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_ad <= '0;
            s1_mode <= '0;
            s1_valid <= 1'b0;
            s2_cost <= '0;
            s2_mode <= '0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_ad <= abs_d;
                s1_mode <= pred_mode;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_cost <= cost;
                s2_mode <= s1_mode;
            end
        end
    end

endmodule

// File: tb/tb_intra4x4_sad_select.sv
// Directed bench for intra4x4_sad_select with a result scoreboard.
// Build with or without INTRA4X4_MPM_BIAS_EN; expectations follow the macro.
module tb_intra4x4_sad_select;

    localparam int SW = 13;
    localparam int ALL1 = (1 << SW) - 1;

    typedef struct packed {
        logic [3:0] m;
        logic [SW-1:0] s;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [3:0] mpm;
    logic [127:0] orig;
    logic pred_valid;
    logic pred_ready;
    logic [127:0] pred;
    logic [3:0] pred_mode;
    logic pred_last;
    logic busy;
    logic done;
    logic [3:0] best_mode;
    logic [SW-1:0] best_sad;

    int tests = 0;
    int fails = 0;
    res_t sb[$];
    logic [127:0] oblk;
    logic [127:0] pblk[9];
    logic [3:0] pmode[9];

    always #5 clk = ~clk;

    intra4x4_sad_select #(.NUM_MODES(9), .SAD_W(SW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef INTRA4X4_MPM_BIAS_EN
        .mpm(mpm),
`endif
        .orig(orig),
        .pred_valid(pred_valid),
        .pred_ready(pred_ready),
        .pred(pred),
        .pred_mode(pred_mode),
        .pred_last(pred_last),
        .busy(busy),
        .done(done),
        .best_mode(best_mode),
        .best_sad(best_sad)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sad_of(logic [127:0] a, logic [127:0] b);
        int s;
        int x;
        int y;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            x = int'(a[8*i +: 8]);
            y = int'(b[8*i +: 8]);
            s += (x > y) ? x - y : y - x;
        end
        return s;
    endfunction

    function automatic int cost_of(int s, logic [3:0] m);
        int c;
        c = s;
`ifdef INTRA4X4_MPM_BIAS_EN
        if (m != mpm) c += 16;
        if (c > ALL1) c = ALL1;
`endif
        return c;
    endfunction

    task automatic decide(input int n, input int last_idx, input bit toggle,
                          input bit mid_start, input bit use_const,
                          input logic [3:0] cm, input int cs);
        int i;
        int phase;
        int guard;
        int w;
        int bs;
        int c;
        logic [3:0] bm;
        bit xf;
        bit fin;
        res_t r;
        bs = ALL1;
        bm = '0;
        i = 0;
        phase = 0;
        guard = 0;
        fin = 1'b0;
        start = 1'b1;
        orig = oblk;
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("ready_after_start", 32'(pred_ready), 1);
        while (!fin && guard < 100) begin
            pred_valid = !(toggle && (phase % 2 == 1));
            pred = pblk[i];
            pred_mode = pmode[i];
            pred_last = (i == last_idx);
            if (mid_start && i == 2) begin
                start = 1'b1;
                orig = ~oblk;
            end
            xf = pred_valid && pred_ready;
            step();
            start = 1'b0;
            if (xf) begin
                c = cost_of(sad_of(oblk, pblk[i]), pmode[i]);
                if (c < bs) begin
                    bs = c;
                    bm = pmode[i];
                end
                fin = pred_last || (i == n - 1);
                i++;
            end
            phase++;
            guard++;
        end
        pred_valid = 1'b0;
        pred_last = 1'b0;
        chk("transfers", 32'(i), (last_idx >= 0) ? 32'(last_idx + 1) : 32'(n));
        if (use_const)
            sb.push_back('{m: cm, s: SW'(cs)});
        else
            sb.push_back('{m: bm, s: SW'(bs)});
        chk("ready_after_last", 32'(pred_ready), 0);
        w = 0;
        while (!done && w < 10) begin
            step();
            w++;
        end
        chk("done_latency", 32'(w), 3);
        chk("busy_at_done", 32'(busy), 1);
        r = sb.pop_front();
        chk("best_mode", 32'(best_mode), 32'(r.m));
        chk("best_sad", 32'(best_sad), 32'(r.s));
        step();
        chk("done_pulse", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("held_sad", 32'(best_sad), 32'(r.s));
        chk("held_mode", 32'(best_mode), 32'(r.m));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        mpm = '0;
        orig = '0;
        pred_valid = 1'b0;
        pred = '0;
        pred_mode = '0;
        pred_last = 1'b0;
        for (int m = 0; m < 9; m++) pmode[m] = 4'(m);

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            start = 1'($urandom);
            pred_valid = 1'($urandom);
            pred_last = 1'($urandom);
            orig = {$urandom, $urandom, $urandom, $urandom};
            pred = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("rst_ready", 32'(pred_ready), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_mode", 32'(best_mode), 0);
            chk("rst_sad", 32'(best_sad), 0);
        end
        start = 1'b0;
        pred_valid = 1'b1;
        pred_last = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("idle_no_done", 32'(done), 0);
            chk("idle_no_ready", 32'(pred_ready), 0);
        end
        pred_valid = 1'b0;

        // Nine modes, mode 4 is an exact copy
        oblk = {16{8'h80}};
        for (int m = 0; m < 9; m++)
            pblk[m] = (m == 4) ? oblk : {16{8'(129 + m)}};
        mpm = 4'd4;
        decide(9, -1, 1'b0, 1'b0, 1'b1, 4'd4, 0);

        // Tie between modes 2 and 5
        mpm = 4'd15;
        for (int m = 0; m < 9; m++)
            pblk[m] = (m == 2 || m == 5) ? {16{8'h84}} : {16{8'h90}};
`ifdef INTRA4X4_MPM_BIAS_EN
        decide(9, -1, 1'b0, 1'b0, 1'b1, 4'd2, 80);
`else
        decide(9, -1, 1'b0, 1'b0, 1'b1, 4'd2, 64);
`endif

        // Early last on third transfer, valid toggling
        mpm = 4'd3;
        oblk = {$urandom, $urandom, $urandom, $urandom};
        for (int m = 0; m < 9; m++)
            pblk[m] = {$urandom, $urandom, $urandom, $urandom};
        decide(9, 2, 1'b1, 1'b0, 1'b0, 4'd0, 0);

        // start during ACCUM must be ignored
        oblk = {$urandom, $urandom, $urandom, $urandom};
        for (int m = 0; m < 9; m++)
            pblk[m] = {$urandom, $urandom, $urandom, $urandom};
        decide(9, -1, 1'b0, 1'b1, 1'b0, 4'd0, 0);

        // Reset between transfers 4 and 5
        start = 1'b1;
        orig = oblk;
        step();
        start = 1'b0;
        pred_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pred = pblk[k];
            pred_mode = pmode[k];
            step();
        end
        pred_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(pred_ready), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_mode", 32'(best_mode), 0);
        chk("midrst_sad", 32'(best_sad), 0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("midrst_no_done", 32'(done), 0);
            chk("midrst_idle", 32'(busy), 0);
        end

        // MPM bias: SAD 10 on mode 0, 20 on mode 1, mpm = 1
        mpm = 4'd1;
        oblk = {16{8'h80}};
        pblk[0] = oblk;
        pblk[0][7:0] = 8'h8a;
        pblk[1] = oblk;
        pblk[1][7:0] = 8'h94;
`ifdef INTRA4X4_MPM_BIAS_EN
        decide(2, 1, 1'b0, 1'b0, 1'b1, 4'd1, 20);
`else
        decide(2, 1, 1'b0, 1'b0, 1'b1, 4'd0, 10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
